data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Slave end of the data-SRAM request/response interface driven by the EXE/MEM pipeline stages.
- Accepts requests on a req/addr_ok handshake. Applies writes to an internal word-addressed memory. Returns in-order responses (data_ok/rdata) after a fixed latency.
- Supports up to DEPTH outstanding transactions.
- Used as the data-side memory model in core simulation and as the template for the later AXI bridge responder.

Parameters:
DEPTH, 4, max outstanding accepted-but-unanswered transactions (power of 2, >=2)
LATENCY, 2, cycles from accept to data_ok (>=1)
MEM_AW, 10, word-address width of internal memory (2**MEM_AW 32-bit words)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
data_sram_req  input  1  request valid
data_sram_wr  input  1  1 = write, 0 = read
data_sram_wstrb  input  4  byte write enables (write only)
data_sram_size  input  2  0 = 1 B, 1 = 2 B, 2 = 4 B; informational, not used for masking
data_sram_addr  input  32  byte address
data_sram_wdata  input  32  write data, byte lanes already replicated by requester
data_sram_addr_ok  output  1  request accepted this cycle
data_sram_data_ok  output  1  response for oldest outstanding transaction
data_sram_rdata  output  32  read data, valid when data_ok
accept_en  input  1  bench throttle; 0 forces addr_ok low
outstanding  output  $clog2(DEPTH)+1  current queue occupancy (debug)

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous, active-low.
- Reset (resetn=0, asynchronous):
  - queue emptied; occupancy 0.
  - all entry timers cleared.
  - addr_ok=0, data_ok=0, rdata=0 immediately.
  - Memory contents are NOT reset.
  - A reset mid-operation discards all outstanding transactions; no data_ok is issued for them.
- Accept: addr_ok = req & accept_en & (occupancy < DEPTH). This is combinational, with no bypass: a full queue refuses the request even if the head pops that cycle. A handshake occurs on a rising edge where req & addr_ok.
- Memory index: word index = addr[MEM_AW+1:2]. addr[1:0] and addr[31:MEM_AW+2] are ignored, so upper bits alias (wrap).
- Write at handshake edge:
  - byte i of mem[index] <= wdata[8i+7:8i] for each wstrb[i]=1.
  - wstrb=4'b0000 leaves memory unchanged but still enqueues and returns data_ok. The requester uses this to cancel stores on exception, ertn or refetch.
- Read at handshake edge:
  - the entry captures mem[index] as of before that edge.
  - Any write accepted earlier is visible; a write accepted later is not.
  - Responses therefore follow strict accept order.
- Queue entry: {is_wr, rdata[31:0], timer}.
  - Circular buffer with head/tail pointers wrapping modulo DEPTH.
  - timer is loaded with LATENCY-1 on enqueue.
  - Every valid entry with timer>0 decrements each cycle, independent of queue position.
- Response:
  - data_ok = (occupancy>0) & (head.timer==0), combinational from registers.
  - The head pops on the same edge that data_ok is high; there is no response backpressure (requester always takes data_ok).
  - rdata = head.rdata when data_ok & ~head.is_wr; otherwise 32'b0.
  - Writes also produce data_ok, with rdata=0.
- Latency: accept on edge ending cycle t gives data_ok in cycle t+LATENCY.
  - Back-to-back accepts give back-to-back data_ok.
  - Throughput is 1 transaction/cycle once LATENCY >= 1 and DEPTH >= LATENCY+1. With smaller DEPTH, addr_ok deasserts when full.
- Simultaneous enqueue and pop: occupancy unchanged; both pointers advance.
- Occupancy: occupancy stays within 0..DEPTH. Enqueue when full and pop when empty are impossible by construction. The bench asserts both never occur.
- req low: addr_ok=0, no state change except timer countdown/pop.
- Inputs other than req are sampled only at the handshake; they may change freely otherwise.

Test Plan:
- Single write then read (LATENCY=2):
  - write addr=0x40, wstrb=4'hF, wdata=0xDEADBEEF accepted in cycle 0 -> data_ok in cycle 2 with rdata=0.
  - read addr=0x40 accepted in cycle 3 -> data_ok in cycle 5 with rdata=0xDEADBEEF.
- Byte/half strobes:
  - write 0x11223344 with wstrb=4'hF, then write wdata=0xAAAAAAAA with wstrb=4'b0010, then write 0x5555_5555 with wstrb=4'b1100.
  - read -> 0x5555AA44.
- Cancelled store: write 0xFFFFFFFF with wstrb=0 to a word holding 0x12345678 -> data_ok still issued; subsequent read returns 0x12345678.
- Back-to-back and full queue:
  - DEPTH=4, LATENCY=6, req held high for 8 cycles -> addr_ok high for the first 4 cycles, low until the first data_ok.
  - exactly 8 data_ok pulses in order; outstanding never exceeds 4.
- Ordering hazard: in consecutive cycles, read A, write A=0x1, read A (A initially 0x0) -> responses rdata 0x0, 0, 0x1.
- Async reset mid-flight: 3 reads outstanding, resetn pulsed low mid-cycle -> data_ok/addr_ok drop immediately, outstanding=0, no responses after reset release; memory retains written data.

Source files
------------

// File: rtl/data_sram_responder.sv
// data_sram_responder: slave end of the data-SRAM request/response interface.
// Requests are accepted on req/addr_ok, writes land in a word-addressed
// memory, and every accepted request is answered in order with data_ok/rdata
// exactly LATENCY cycles after its accept. Up to DEPTH requests may be in
// flight. MEM_AW is expected to stay below 30 so that the ignored upper
// address bits exist.

module data_sram_responder #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int MEM_AW  = 10
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     data_sram_req,
    input  logic                     data_sram_wr,
    input  logic [3:0]               data_sram_wstrb,
    input  logic [1:0]               data_sram_size,
    input  logic [31:0]              data_sram_addr,
    input  logic [31:0]              data_sram_wdata,
    output logic                     data_sram_addr_ok,
    output logic                     data_sram_data_ok,
    output logic [31:0]              data_sram_rdata,
    input  logic                     accept_en,
    output logic [$clog2(DEPTH):0]   outstanding
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [TW-1:0] TIMER_INIT = TW'(LATENCY - 1);
    localparam logic [PW:0]   DEPTH_CNT  = (PW + 1)'(DEPTH);

    // Backing store; deliberately never reset so data survives a reset pulse.
    logic [31:0] r_mem [0:(1 << MEM_AW) - 1];

    // Response queue: circular buffer of {is_wr, rdata, timer} plus a valid bit.
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_isWr;
    logic [31:0]      r_data  [DEPTH];
    logic [TW-1:0]    r_timer [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;

    logic [MEM_AW-1:0] w_index;
    logic              w_addrOk;
    logic              w_push;
    logic              w_dataOk;
    logic              w_unused;

    // Size and the byte-offset / aliased upper address bits carry no meaning here.
    assign w_unused = ^{data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

    assign w_index  = data_sram_addr[MEM_AW+1:2];

    // No bypass: a full queue refuses even when the head leaves this cycle.
    // Reset is folded in so addr_ok drops the moment resetn goes low.
    assign w_addrOk = resetn & data_sram_req & accept_en & (r_count < DEPTH_CNT);
    assign w_push   = data_sram_req & w_addrOk;

    // The head answers once its own countdown has expired.
    assign w_dataOk = (r_count != '0) & (r_timer[r_head] == '0);

    assign data_sram_addr_ok = w_addrOk;
    assign data_sram_data_ok = w_dataOk;
    assign data_sram_rdata   = (w_dataOk && !r_isWr[r_head]) ? r_data[r_head] : 32'h0;
    assign outstanding       = r_count;

    // Byte-masked memory write at the handshake edge; an all-zero strobe is a cancelled store.
    always_ff @(posedge clk) begin
        if (w_push && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    r_mem[w_index][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Queue bookkeeping: per-entry countdown, head pop on data_ok, tail push on handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            r_isWr  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i]  <= 32'h0;
                r_timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && (r_timer[i] != '0)) begin
                    r_timer[i] <= r_timer[i] - 1'b1;
                end
            end

            if (w_dataOk) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end

            // The read captures memory as it was before this edge's write.
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_isWr[r_tail]  <= data_sram_wr;
                r_data[r_tail]  <= data_sram_wr ? 32'h0 : r_mem[w_index];
                r_timer[r_tail] <= TIMER_INIT;
                r_tail          <= r_tail + 1'b1;
            end

            case ({w_push, w_dataOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder. Two instances share one request bus:
// instance 0 uses LATENCY=2, instance 1 uses LATENCY=6 so that a DEPTH=4
// queue can actually fill. A reference model keeps, per instance, a queue of
// {due cycle, response data} and a plain memory array.

module tb_data_sram_responder;

    localparam int DEP  = 4;
    localparam int LAT0 = 2;
    localparam int LAT1 = 6;
    localparam int AW   = 10;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        acceptEn;

    logic [1:0]       addrOk;
    logic [1:0]       dataOk;
    logic [1:0][31:0] rdataV;
    logic [1:0][2:0]  outst;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } entry_t;

    entry_t      mq[2][$];
    logic [31:0] mMem[2][1024];

    always #5 clk = ~clk;

    data_sram_responder #(.DEPTH(DEP), .LATENCY(LAT0), .MEM_AW(AW)) u_dut0 (
        .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_wstrb(wstrb), .data_sram_size(size), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(addrOk[0]),
        .data_sram_data_ok(dataOk[0]), .data_sram_rdata(rdataV[0]),
        .accept_en(acceptEn), .outstanding(outst[0])
    );

    data_sram_responder #(.DEPTH(DEP), .LATENCY(LAT1), .MEM_AW(AW)) u_dut1 (
        .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_wstrb(wstrb), .data_sram_size(size), .data_sram_addr(addr),
        .data_sram_wdata(wdata), .data_sram_addr_ok(addrOk[1]),
        .data_sram_data_ok(dataOk[1]), .data_sram_rdata(rdataV[1]),
        .accept_en(acceptEn), .outstanding(outst[1])
    );

    function automatic int latOf(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic expAddrOk(input int k);
        return resetn && req && acceptEn && (mq[k].size() < DEP);
    endfunction

    function automatic logic expDataOk(input int k);
        return resetn && (mq[k].size() > 0) && (mq[k][0].due == cyc);
    endfunction

    // Reset throws away every pending response in the model.
    always @(negedge resetn) begin
        mq[0].delete();
        mq[1].delete();
    end

    // Model step at each rising edge: retire the due head, then take a new request.
    always @(posedge clk) begin : modelStep
        logic        mAcc;
        logic [9:0]  mIdx;
        entry_t      mE;
        if (resetn === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                mAcc = req && acceptEn && (mq[k].size() < DEP);
                if ((mq[k].size() > 0) && (mq[k][0].due == cyc)) begin
                    void'(mq[k].pop_front());
                end
                if (mAcc) begin
                    mIdx    = addr[11:2];
                    mE.due  = cyc + latOf(k);
                    mE.data = wr ? 32'h0 : mMem[k][mIdx];
                    mq[k].push_back(mE);
                    if (wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[b]) mMem[k][mIdx][8*b +: 8] = wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    task automatic setBus(input logic r, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        req   = r;
        wr    = w;
        wstrb = s;
        addr  = a;
        wdata = d;
        size  = 2'd2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            setBus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
    endtask

    // One isolated transaction; reports instance-0 accept, latency and response data.
    task automatic doTxn(input logic isWr, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, output logic acc, output int lat,
                         output logic [31:0] rd);
        @(negedge clk);
        setBus(1'b1, isWr, s, a, d);
        #1 acc = addrOk[0];
        @(negedge clk);
        setBus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        lat = -1;
        rd  = 32'hx;
        for (int i = 1; i <= 20; i++) begin
            if (dataOk[0]) begin
                lat = i;
                rd  = rdataV[0];
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        resetn   = 1'b0;
        acceptEn = 1'b1;
        setBus(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        #3;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (addrOk[k] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_addr_ok[%0d]: got %b expected 0", k, addrOk[k]);
            end
            vectors++;
            if (dataOk[k] !== 1'b0 || rdataV[k] !== 32'h0 || outst[k] !== 3'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs[%0d]: got ok=%b rdata=%h occ=%0d expected 0/0/0",
                         k, dataOk[k], rdataV[k], outst[k]);
            end
        end
        @(negedge clk);
        setBus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        idle(2);
    endtask

    task automatic test_single_write_read;
        logic acc; int lat; logic [31:0] rd;
        doTxn(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, acc, lat, rd);
        vectors++;
        if (acc !== 1'b1 || lat != LAT0 || rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL single_write: got acc=%b lat=%0d rdata=%h expected 1/%0d/00000000", acc, lat, rd, LAT0);
        end
        doTxn(1'b0, 4'h0, 32'h40, 32'h0, acc, lat, rd);
        vectors++;
        if (acc !== 1'b1 || lat != LAT0 || rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL single_read: got acc=%b lat=%0d rdata=%h expected 1/%0d/deadbeef", acc, lat, rd, LAT0);
        end
    endtask

    task automatic test_strobes;
        logic acc; int lat; logic [31:0] rd;
        doTxn(1'b1, 4'hF,    32'h80, 32'h11223344, acc, lat, rd);
        doTxn(1'b1, 4'b0010, 32'h80, 32'hAAAAAAAA, acc, lat, rd);
        doTxn(1'b1, 4'b1100, 32'h80, 32'h55555555, acc, lat, rd);
        vectors++;
        if (lat != LAT0 || rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL strobe_write_resp: got lat=%0d rdata=%h expected %0d/00000000", lat, rd, LAT0);
        end
        doTxn(1'b0, 4'h0, 32'h80, 32'h0, acc, lat, rd);
        vectors++;
        if (rd !== 32'h5555AA44) begin
            miscompares++;
            $display("[TB] FAIL strobe_merge: got %h expected 5555aa44", rd);
        end
    endtask

    task automatic test_cancelled_store;
        logic acc; int lat; logic [31:0] rd;
        doTxn(1'b1, 4'hF, 32'hC0, 32'h12345678, acc, lat, rd);
        doTxn(1'b1, 4'h0, 32'hC0, 32'hFFFFFFFF, acc, lat, rd);
        vectors++;
        if (acc !== 1'b1 || lat != LAT0 || rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL cancel_resp: got acc=%b lat=%0d rdata=%h expected 1/%0d/00000000", acc, lat, rd, LAT0);
        end
        doTxn(1'b0, 4'h0, 32'hC0, 32'h0, acc, lat, rd);
        vectors++;
        if (rd !== 32'h12345678) begin
            miscompares++;
            $display("[TB] FAIL cancel_keep: got %h expected 12345678", rd);
        end
    endtask

    task automatic test_hazard;
        logic acc; int lat; logic [31:0] rd;
        logic expOk; logic [31:0] expRd;
        doTxn(1'b1, 4'hF, 32'h100, 32'h0, acc, lat, rd);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            expOk = (i >= 2) && (i <= 4);
            expRd = (i == 4) ? 32'h1 : 32'h0;
            vectors++;
            if (dataOk[0] !== expOk || rdataV[0] !== expRd) begin
                miscompares++;
                $display("[TB] FAIL hazard_cycle%0d: got ok=%b rdata=%h expected %b/%h", i, dataOk[0], rdataV[0], expOk, expRd);
            end
            case (i)
                0:       setBus(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
                1:       setBus(1'b1, 1'b1, 4'hF, 32'h100, 32'h1);
                2:       setBus(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
                default: setBus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            endcase
        end
    endtask

    task automatic test_full_queue;
        logic acc; int lat; logic [31:0] rd;
        int hs; int pulses;
        for (int j = 0; j < 8; j++) begin
            doTxn(1'b1, 4'hF, 32'h200 + 32'(4*j), 32'hA0000000 + 32'(j), acc, lat, rd);
        end
        idle(10);
        hs = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                vectors++;
                if (outst[1] !== 3'd0) begin
                    miscompares++;
                    $display("[TB] FAIL full_start_occ: got %0d expected 0", outst[1]);
                end
            end
            if (dataOk[1]) begin
                vectors++;
                if (rdataV[1] !== 32'hA0000000 + 32'(pulses)) begin
                    miscompares++;
                    $display("[TB] FAIL full_order: got %h expected %h", rdataV[1], 32'hA0000000 + 32'(pulses));
                end
                pulses++;
            end
            if (outst[1] > 3'd4) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL full_occ_bound: got %0d expected <=4", outst[1]);
            end
            if (hs < 8) setBus(1'b1, 1'b0, 4'h0, 32'h200 + 32'(4*hs), 32'h0);
            else        setBus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            #1;
            if (i <= 6) begin
                vectors++;
                if (addrOk[1] !== (i < 4)) begin
                    miscompares++;
                    $display("[TB] FAIL full_addr_ok_cycle%0d: got %b expected %b", i, addrOk[1], (i < 4));
                end
            end
            if (req && addrOk[1]) begin
                if (outst[1] == 3'd4) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL full_enqueue_when_full: got accept expected refuse");
                end
                hs++;
            end
        end
        vectors++;
        if (hs != 8 || pulses != 8) begin
            miscompares++;
            $display("[TB] FAIL full_counts: got accepts=%0d responses=%0d expected 8/8", hs, pulses);
        end
    endtask

    task automatic test_async_reset;
        logic acc; int lat; logic [31:0] rd;
        int late;
        doTxn(1'b1, 4'hF, 32'h300, 32'hCAFEF00D, acc, lat, rd);
        idle(10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            setBus(1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
        end
        #1;
        vectors++;
        if (outst[1] !== 3'd3 || dataOk[0] !== 1'b1 || addrOk[1] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_state: got occ1=%0d ok0=%b aok1=%b expected 3/1/1", outst[1], dataOk[0], addrOk[1]);
        end
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (addrOk[k] !== 1'b0 || dataOk[k] !== 1'b0 || rdataV[k] !== 32'h0 || outst[k] !== 3'd0) begin
                miscompares++;
                $display("[TB] FAIL midflight_reset[%0d]: got aok=%b ok=%b rdata=%h occ=%0d expected 0/0/0/0",
                         k, addrOk[k], dataOk[k], rdataV[k], outst[k]);
            end
        end
        @(negedge clk);
        setBus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
        late = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dataOk != 2'b00 || outst[0] != 3'd0 || outst[1] != 3'd0) late++;
        end
        vectors++;
        if (late != 0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_silence: got %0d active cycles expected 0", late);
        end
        doTxn(1'b0, 4'h0, 32'h300, 32'h0, acc, lat, rd);
        vectors++;
        if (rd !== 32'hCAFEF00D || lat != LAT0) begin
            miscompares++;
            $display("[TB] FAIL mem_retained: got %h lat=%0d expected cafef00d lat=%0d", rd, lat, LAT0);
        end
    endtask

    task automatic test_random;
        logic acc; int lat; logic [31:0] rd;
        logic [31:0] a;
        logic eOk;
        logic [31:0] eRd;
        for (int j = 0; j < 16; j++) begin
            doTxn(1'b1, 4'hF, 32'h400 + 32'(4*j), $urandom(), acc, lat, rd);
        end
        idle(10);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                eOk = expDataOk(k);
                eRd = eOk ? mq[k][0].data : 32'h0;
                vectors++;
                if (dataOk[k] !== eOk || rdataV[k] !== eRd) begin
                    miscompares++;
                    $display("[TB] FAIL rand_resp[%0d] cyc %0d: got ok=%b rdata=%h expected %b/%h", k, cyc, dataOk[k], rdataV[k], eOk, eRd);
                end
                vectors++;
                if (outst[k] !== 3'(mq[k].size())) begin
                    miscompares++;
                    $display("[TB] FAIL rand_occ[%0d] cyc %0d: got %0d expected %0d", k, cyc, outst[k], mq[k].size());
                end
            end
            a = $urandom();
            a[11:2] = {6'b010000, 4'($urandom_range(0, 15))};
            setBus($urandom_range(0, 9) < 7, 1'($urandom()), 4'($urandom()), a, $urandom());
            size     = 2'($urandom_range(0, 2));
            acceptEn = $urandom_range(0, 19) < 17;
            #1;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (addrOk[k] !== expAddrOk(k)) begin
                    miscompares++;
                    $display("[TB] FAIL rand_addr_ok[%0d] cyc %0d: got %b expected %b", k, cyc, addrOk[k], expAddrOk(k));
                end
            end
        end
        acceptEn = 1'b1;
        idle(10);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write_read();
        test_strobes();
        test_cancelled_store();
        test_hazard();
        test_full_queue();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
